// File: rtl/gmem_rd_channel_mux.sv
// Shares one AXI4 gmem read master among NUM_CH requestors: round-robin AR arbitration into a
// single registered AR stage, RID-based R routing, and per-channel in-flight burst credits.
module gmem_rd_channel_mux #(
  parameter int NUM_CH          = 4,
  parameter int ADDR_W          = 42,
  parameter int DATA_W          = 512,
  parameter int ID_W            = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_CH-1:0]        ch_ar_valid,
  output logic [NUM_CH-1:0]        ch_ar_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_ar_addr,
  input  logic [NUM_CH*8-1:0]      ch_ar_len,
  output logic [NUM_CH-1:0]        ch_r_valid,
  input  logic [NUM_CH-1:0]        ch_r_ready,
  output logic [DATA_W-1:0]        ch_r_data,
  output logic                     ch_r_last,
  output logic                     m_axi_gmem_ARVALID,
  input  logic                     m_axi_gmem_ARREADY,
  output logic [ADDR_W-1:0]        m_axi_gmem_ARADDR,
  output logic [ID_W-1:0]          m_axi_gmem_ARID,
  output logic [7:0]               m_axi_gmem_ARLEN,
  output logic [2:0]               m_axi_gmem_ARSIZE,
  output logic [1:0]               m_axi_gmem_ARBURST,
  output logic [1:0]               m_axi_gmem_ARLOCK,
  output logic [3:0]               m_axi_gmem_ARCACHE,
  output logic [2:0]               m_axi_gmem_ARPROT,
  output logic [3:0]               m_axi_gmem_ARQOS,
  output logic [3:0]               m_axi_gmem_ARREGION,
  input  logic                     m_axi_gmem_RVALID,
  output logic                     m_axi_gmem_RREADY,
  input  logic [DATA_W-1:0]        m_axi_gmem_RDATA,
  input  logic                     m_axi_gmem_RLAST,
  input  logic [ID_W-1:0]          m_axi_gmem_RID,
  input  logic [1:0]               m_axi_gmem_RRESP,
  output logic [NUM_CH*8-1:0]      outstanding,
  output logic [1:0]               err
);

  localparam int PTR_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0][7:0]        r_cnt;
  logic [1:0]                    r_err;
  logic [PTR_W-1:0]              r_rr_ptr;
  logic                          r_arvalid;
  logic [ADDR_W-1:0]             r_araddr;
  logic [ID_W-1:0]               r_arid;
  logic [7:0]                    r_arlen;

  logic [NUM_CH-1:0][ADDR_W-1:0] w_addr_v;
  logic [NUM_CH-1:0][7:0]        w_len_v;
  logic [NUM_CH-1:0]             w_elig, w_zero, w_dec;
  logic [PTR_W-1:0]              w_gnt, w_gnt_hi, w_gnt_lo, w_ptr_nxt;
  logic                          w_found, w_found_hi, w_load;
  logic                          w_rid_ok, w_rready;
  logic                          w_unused_rresp;

  assign w_addr_v = ch_ar_addr;
  assign w_len_v  = ch_ar_len;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = ch_ar_valid[i] && (r_cnt[i] < 8'(MAX_OUTSTANDING));
      w_zero[i] = (r_cnt[i] == 8'd0);
    end
  end

  // Two descending scans: lowest eligible at/after the pointer wins, else lowest eligible overall.
  always_comb begin
    w_gnt_hi   = '0;
    w_gnt_lo   = '0;
    w_found    = 1'b0;
    w_found_hi = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_gnt_lo = PTR_W'(i);
        w_found  = 1'b1;
        if (i >= int'(r_rr_ptr)) begin
          w_gnt_hi   = PTR_W'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_gnt = w_found_hi ? w_gnt_hi : w_gnt_lo;
  end

  assign w_ptr_nxt   = (w_gnt == PTR_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
  assign w_load      = !r_arvalid || m_axi_gmem_ARREADY;
  assign ch_ar_ready = (w_load && w_found && !ap_rst) ? (NUM_CH'(1) << w_gnt) : '0;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_arvalid <= 1'b0;
      r_rr_ptr  <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arid    <= '0;
    end else if (w_load) begin
      r_arvalid <= w_found;
      if (w_found) begin
        r_araddr <= w_addr_v[w_gnt];
        r_arlen  <= w_len_v[w_gnt];
        r_arid   <= ID_W'(w_gnt);
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign m_axi_gmem_ARVALID  = r_arvalid;
  assign m_axi_gmem_ARADDR   = r_araddr;
  assign m_axi_gmem_ARID     = r_arid;
  assign m_axi_gmem_ARLEN    = r_arlen;
  assign m_axi_gmem_ARSIZE   = 3'($clog2(DATA_W / 8));
  assign m_axi_gmem_ARBURST  = 2'b01;
  assign m_axi_gmem_ARLOCK   = '0;
  assign m_axi_gmem_ARCACHE  = '0;
  assign m_axi_gmem_ARPROT   = '0;
  assign m_axi_gmem_ARQOS    = '0;
  assign m_axi_gmem_ARREGION = '0;

  // Unknown RIDs are swallowed so a stray beat can never wedge the shared R channel.
  always_comb begin
    w_rid_ok = 1'b0;
    w_rready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_r_valid[i] = m_axi_gmem_RVALID && (m_axi_gmem_RID == ID_W'(i));
      if (m_axi_gmem_RID == ID_W'(i)) begin
        w_rid_ok = 1'b1;
        w_rready = ch_r_ready[i];
      end
    end
  end

  assign m_axi_gmem_RREADY = w_rready;
  assign ch_r_data         = m_axi_gmem_RDATA;
  assign ch_r_last         = m_axi_gmem_RLAST;
  assign w_dec             = ch_r_valid & {NUM_CH{w_rready && m_axi_gmem_RLAST}};
  assign w_unused_rresp    = ^m_axi_gmem_RRESP;

  // Credits are taken at grant time so a channel cannot be granted past its cap while its AR waits.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_ar_ready[i] && !(w_dec[i] && !w_zero[i]))
          r_cnt[i] <= r_cnt[i] + 8'd1;
        else if (!ch_ar_ready[i] && w_dec[i] && !w_zero[i])
          r_cnt[i] <= r_cnt[i] - 8'd1;
      end
      if (m_axi_gmem_RVALID && !w_rid_ok) r_err[0] <= 1'b1;
      if (|(w_dec & w_zero))               r_err[1] <= 1'b1;
    end
  end

  assign outstanding = r_cnt;
  assign err         = r_err;

endmodule

// File: tb/tb_gmem_rd_channel_mux.sv
// Directed bench for gmem_rd_channel_mux: per-cycle comparison against a queue/arithmetic model
// plus literal expectations for each scenario.
module tb_gmem_rd_channel_mux;
  localparam int NC = 4, AW = 42, DW = 512, IW = 3, MAXO = 2;

  logic ap_clk = 1'b0, ap_rst = 1'b1;
  logic [NC-1:0] ch_ar_valid = '0, ch_ar_ready, ch_r_valid, ch_r_ready = '0;
  logic [AW-1:0] a [NC];
  logic [7:0]    ln [NC];
  logic [NC*AW-1:0] ch_ar_addr;
  logic [NC*8-1:0]  ch_ar_len, outstanding;
  logic [DW-1:0] ch_r_data, RDATA = '0;
  logic ch_r_last, ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY, RLAST = 1'b0;
  logic [AW-1:0] ARADDR;
  logic [IW-1:0] ARID, RID = '0;
  logic [7:0] ARLEN;
  logic [2:0] ARSIZE, ARPROT;
  logic [1:0] ARBURST, ARLOCK, RRESP = 2'b00, err;
  logic [3:0] ARCACHE, ARQOS, ARREGION;

  assign ch_ar_addr = {a[3], a[2], a[1], a[0]};
  assign ch_ar_len  = {ln[3], ln[2], ln[1], ln[0]};

  always #5 ap_clk = ~ap_clk;

  gmem_rd_channel_mux #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTSTANDING(MAXO)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .ch_ar_valid(ch_ar_valid), .ch_ar_ready(ch_ar_ready), .ch_ar_addr(ch_ar_addr), .ch_ar_len(ch_ar_len),
    .ch_r_valid(ch_r_valid), .ch_r_ready(ch_r_ready), .ch_r_data(ch_r_data), .ch_r_last(ch_r_last),
    .m_axi_gmem_ARVALID(ARVALID), .m_axi_gmem_ARREADY(ARREADY), .m_axi_gmem_ARADDR(ARADDR),
    .m_axi_gmem_ARID(ARID), .m_axi_gmem_ARLEN(ARLEN), .m_axi_gmem_ARSIZE(ARSIZE),
    .m_axi_gmem_ARBURST(ARBURST), .m_axi_gmem_ARLOCK(ARLOCK), .m_axi_gmem_ARCACHE(ARCACHE),
    .m_axi_gmem_ARPROT(ARPROT), .m_axi_gmem_ARQOS(ARQOS), .m_axi_gmem_ARREGION(ARREGION),
    .m_axi_gmem_RVALID(RVALID), .m_axi_gmem_RREADY(RREADY), .m_axi_gmem_RDATA(RDATA),
    .m_axi_gmem_RLAST(RLAST), .m_axi_gmem_RID(RID), .m_axi_gmem_RRESP(RRESP),
    .outstanding(outstanding), .err(err));

  int n_tot = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: counts per channel, a round-robin start index, and the one pending AR.
  bit         m_on = 1'b0, m_arv;
  int         m_cnt [NC];
  int         m_rr;
  logic [AW-1:0] m_addr;
  logic [7:0] m_len;
  logic [IW-1:0] m_id;
  logic [1:0] m_err;

  function automatic int m_grant();
    for (int k = 0; k < NC; k++) begin
      int c = (m_rr + k) % NC;
      if (ch_ar_valid[c] && m_cnt[c] < MAXO) return c;
    end
    return -1;
  endfunction

  function automatic bit m_rready();
    if (int'(RID) >= NC) return 1'b1;
    return ch_r_ready[RID];
  endfunction

  always @(posedge ap_clk) begin : mdl
    int g;
    if (ap_rst) begin
      m_on = 1'b1; m_arv = 1'b0; m_rr = 0; m_err = 2'b00;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    end else if (m_on) begin
      g = m_grant();
      if (RVALID && int'(RID) >= NC) m_err[0] = 1'b1;
      if (RVALID && int'(RID) < NC && RLAST && m_rready()) begin
        if (m_cnt[RID] == 0) m_err[1] = 1'b1;
        else m_cnt[RID] = m_cnt[RID] - 1;
      end
      if (!m_arv || ARREADY) begin
        if (g >= 0) begin
          m_arv = 1'b1; m_addr = a[g]; m_len = ln[g]; m_id = IW'(g);
          m_cnt[g] = m_cnt[g] + 1; m_rr = (g + 1) % NC;
        end else m_arv = 1'b0;
      end
    end
  end

  always @(negedge ap_clk) begin : cmp
    int g;
    logic [NC-1:0] erdy, ervld;
    logic [NC*8-1:0] eo;
    if (m_on) begin
      g = m_grant();
      erdy = (!ap_rst && (!m_arv || ARREADY) && g >= 0) ? NC'(1) << g : '0;
      ervld = (RVALID && int'(RID) < NC) ? NC'(1) << RID : '0;
      for (int i = 0; i < NC; i++) eo[i*8 +: 8] = 8'(m_cnt[i]);
      chk("m_arvalid", ARVALID, m_arv);
      if (m_arv) chk("m_ar_fields", {ARADDR, ARLEN, ARID}, {m_addr, m_len, m_id});
      chk("m_ch_ar_ready", ch_ar_ready, erdy);
      chk("m_outstanding", outstanding, eo);
      chk("m_err", err, m_err);
      chk("m_ch_r_valid", ch_r_valid, ervld);
      chk("m_rready", RREADY, m_rready());
      if (RVALID) begin
        chk("m_r_data_lo", ch_r_data[63:0], RDATA[63:0]);
        chk("m_r_data_hi", ch_r_data[511:448], RDATA[511:448]);
        chk("m_r_last", ch_r_last, RLAST);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1; ch_ar_valid = '0; ch_r_ready = '0; ARREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; RID = '0;
    tick(2);
    ap_rst = 1'b0;
  endtask

  logic [IW-1:0] ids [$];
  logic [IW-1:0] exp_ids [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};

  initial begin
    for (int i = 0; i < NC; i++) begin a[i] = AW'(32'h2000 + i * 32'h100); ln[i] = 8'(i + 3); end

    // T1: single request, latency and fixed fields
    do_reset();
    @(negedge ap_clk);
    chk("rst_arvalid", ARVALID, 0); chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0); chk("rst_ch_ar_ready", ch_ar_ready, 0);
    a[0] = 42'h1000; ln[0] = 8'd7; ch_ar_valid = 4'b0001; ARREADY = 1'b1;
    #1;
    chk("t1_ready", ch_ar_ready, 4'b0001);
    tick(); ch_ar_valid = '0;
    @(negedge ap_clk);
    chk("t1_arvalid", ARVALID, 1); chk("t1_araddr", ARADDR, 42'h1000); chk("t1_arlen", ARLEN, 7);
    chk("t1_arid", ARID, 0); chk("t1_arsize", ARSIZE, 6); chk("t1_arburst", ARBURST, 1);
    chk("t1_out0", outstanding[7:0], 1);
    tick();

    // T2: all channels, round-robin, one AR per cycle until all capped at 2
    do_reset();
    ch_ar_valid = 4'b1111; ARREADY = 1'b1;
    repeat (12) begin
      @(negedge ap_clk);
      if (ARVALID) ids.push_back(ARID);
    end
    chk("t2_num_ar", ids.size(), 8);
    for (int k = 0; k < 8 && k < ids.size(); k++) chk("t2_arid_seq", ids[k], exp_ids[k]);
    chk("t2_outstanding", outstanding, 32'h02020202);
    chk("t2_arvalid_idle", ARVALID, 0);
    #1; ch_ar_valid = '0;
    tick();

    // T3: AR stall holds fields, then the next channel in order is granted
    do_reset();
    ch_ar_valid = 4'b1111; ARREADY = 1'b0;
    tick();
    repeat (5) begin
      @(negedge ap_clk);
      chk("t3_no_ready", ch_ar_ready, 0); chk("t3_arid_hold", ARID, 0); chk("t3_araddr_hold", ARADDR, 42'h1000);
    end
    #1; ARREADY = 1'b1;
    #1; chk("t3_resume_ch1", ch_ar_ready, 4'b0010);
    tick(); ch_ar_valid = '0;
    @(negedge ap_clk);
    chk("t3_arid1", ARID, 1);
    tick();

    // T4: credit cap excludes ch1, ch2 still served, ch1 returns after RLAST
    do_reset();
    ARREADY = 1'b1; ch_r_ready = 4'b1111; ch_ar_valid = 4'b0010;
    @(negedge ap_clk); chk("t4_g1", ch_ar_ready, 4'b0010);
    tick();
    @(negedge ap_clk); chk("t4_g2", ch_ar_ready, 4'b0010);
    tick();
    @(negedge ap_clk); chk("t4_out1_cap", outstanding[15:8], 2); chk("t4_capped", ch_ar_ready, 0);
    #1; ch_ar_valid = 4'b0110;
    #1; chk("t4_ch2", ch_ar_ready, 4'b0100);
    tick();
    ch_ar_valid = 4'b0010; RVALID = 1'b1; RID = 3'd1; RLAST = 1'b1; RDATA = {8{64'hA5A5_0001_DEAD_BEEF}};
    @(negedge ap_clk); chk("t4_still_capped", ch_ar_ready, 0); chk("t4_rready", RREADY, 1);
    tick(); RVALID = 1'b0; RLAST = 1'b0;
    @(negedge ap_clk); chk("t4_out1_dec", outstanding[15:8], 1); chk("t4_ch1_again", ch_ar_ready, 4'b0010);
    tick(); ch_ar_valid = '0;

    // T5: interleaved beats, ch0 stalled
    do_reset();
    ARREADY = 1'b1; ch_ar_valid = 4'b0100;
    tick(); ch_ar_valid = '0; ch_r_ready = 4'b0100;
    RVALID = 1'b1; RID = 3'd2; RLAST = 1'b0; RDATA = {8{64'h1111_2222_3333_4444}};
    @(negedge ap_clk);
    chk("t5_rready_b1", RREADY, 1); chk("t5_rvalid_b1", ch_r_valid, 4'b0100); chk("t5_out2", outstanding[23:16], 1);
    tick(); RID = 3'd0; RDATA = {8{64'h5555_6666_7777_8888}};
    @(negedge ap_clk); chk("t5_rready_stall", RREADY, 0); chk("t5_rvalid_b2", ch_r_valid, 4'b0001);
    tick();
    @(negedge ap_clk); chk("t5_rready_stall2", RREADY, 0);
    #1; ch_r_ready = 4'b0101;
    #1; chk("t5_rready_go", RREADY, 1);
    tick(); RID = 3'd2; RLAST = 1'b1; ch_r_ready = 4'b0100;
    @(negedge ap_clk); chk("t5_out2_pre", outstanding[23:16], 1); chk("t5_last", ch_r_last, 1);
    tick(); RVALID = 1'b0; RLAST = 1'b0;
    @(negedge ap_clk); chk("t5_out2_post", outstanding[23:16], 0);

    // T6: error flags, then reset during a burst with a late beat
    #1; RVALID = 1'b1; RID = 3'd5;
    #1; chk("t6_rready_bad", RREADY, 1); chk("t6_rvalid_bad", ch_r_valid, 0);
    tick(); RVALID = 1'b0;
    @(negedge ap_clk); chk("t6_err0", err, 2'b01);
    tick(3);
    @(negedge ap_clk); chk("t6_err0_sticky", err, 2'b01);
    #1; RVALID = 1'b1; RID = 3'd3; RLAST = 1'b1; ch_r_ready = 4'b1000;
    tick(); RVALID = 1'b0; RLAST = 1'b0;
    @(negedge ap_clk); chk("t6_err1", err, 2'b11); chk("t6_out3_zero", outstanding[31:24], 0);
    #1; ARREADY = 1'b0; ch_ar_valid = 4'b0001;
    tick(); ch_ar_valid = '0;
    @(negedge ap_clk); chk("t6_arvalid_pre", ARVALID, 1); chk("t6_out0_pre", outstanding[7:0], 1);
    #1; ap_rst = 1'b1; RVALID = 1'b1; RID = 3'd1; ch_r_ready = 4'b0010;
    tick();
    @(negedge ap_clk);
    chk("t6_rst_arvalid", ARVALID, 0); chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_err", err, 0); chk("t6_late_route", ch_r_valid, 4'b0010);
    #1; ap_rst = 1'b0; RVALID = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
